// File: rtl/trace_capture_if.sv
// Event capture and drain bus for the trace capture unit.
// The producer side presents per-channel events and accepts drained entries;
// the trace unit consumes events and presents the FIFO head.
interface trace_capture_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 128,
    parameter int IDX_W  = 10,
    parameter int TS_W   = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        ev_valid;
    logic [NUM_CH*IDX_W-1:0]  ev_idx;
    logic [NUM_CH*DATA_W-1:0] ev_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [CH_W-1:0]          rd_ch;
    logic [IDX_W-1:0]         rd_idx;
    logic [DATA_W-1:0]        rd_data;
    logic [TS_W-1:0]          rd_ts;

    modport master (
        output ev_valid, ev_idx, ev_data, rd_ready,
        input  rd_valid, rd_ch, rd_idx, rd_data, rd_ts
    );

    modport slave (
        input  ev_valid, ev_idx, ev_data, rd_ready,
        output rd_valid, rd_ch, rd_idx, rd_data, rd_ts
    );
endinterface

// File: rtl/trace_capture_unit.sv
// Multi-channel architectural event trace buffer.
// Events are latched into one holding register per channel, a fixed-priority
// arbiter moves one holding register per cycle into a FIFO, and the FIFO head
// drains over a valid/ready port. Entries carry channel, index, data and the
// timestamp of the cycle the event was presented.
module trace_capture_unit #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 128,
    parameter int IDX_W     = 10,
    parameter int TS_W      = 32,
    parameter int DEPTH     = 64,
    parameter int WRAP_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freeze,
    input  logic                   clear,
    trace_capture_if.slave         bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int LW   = $clog2(NUM_CH + 1);

    logic [TS_W-1:0]   ts_r;
    logic [NUM_CH-1:0] hold_v_r;
    logic [IDX_W-1:0]  hold_idx_r  [NUM_CH];
    logic [DATA_W-1:0] hold_data_r [NUM_CH];
    logic [TS_W-1:0]   hold_ts_r   [NUM_CH];

    logic [CH_W-1:0]   mem_ch_r    [DEPTH];
    logic [IDX_W-1:0]  mem_idx_r   [DEPTH];
    logic [DATA_W-1:0] mem_data_r  [DEPTH];
    logic [TS_W-1:0]   mem_ts_r    [DEPTH];

    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic              overflow_r;
    logic [15:0]       drop_cnt_r;

    logic              grant_valid_s;
    logic [CH_W-1:0]   grant_ch_s;
    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              overwrite_s;
    logic [NUM_CH-1:0] release_s;
    logic [NUM_CH-1:0] load_s;
    logic [NUM_CH-1:0] lost_s;
    logic [LW-1:0]     lost_num_s;
    logic [16:0]       drop_sum_s;
    logic [15:0]       drop_next_s;
    logic [AW-1:0]     rd_addr_s;
    logic [AW-1:0]     wr_addr_s;

    // Fixed-priority arbiter: the lowest-index valid holding register wins.
    always_comb begin
        grant_valid_s = |hold_v_r;
        grant_ch_s    = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            grant_ch_s = hold_v_r[c] ? CH_W'(c) : grant_ch_s;
        end
    end

    // FIFO status and the push/pop/overwrite decisions for this cycle.
    always_comb begin
        empty_s     = (wr_ptr_r == rd_ptr_r);
        full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s       = !empty_s && bus.rd_ready;
        push_s      = grant_valid_s && ((WRAP_MODE != 0) || !full_s || pop_s);
        overwrite_s = push_s && full_s && !pop_s;
    end

    // Per-channel capture: a holding register accepts a new event when empty or
    // when its current content is pushed this cycle; otherwise the event is lost.
    always_comb begin
        release_s  = '0;
        load_s     = '0;
        lost_s     = '0;
        lost_num_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            release_s[c] = push_s && (grant_ch_s == CH_W'(c));
            load_s[c]    = bus.ev_valid[c] && !freeze && (!hold_v_r[c] || release_s[c]);
            lost_s[c]    = bus.ev_valid[c] && !freeze && hold_v_r[c] && !release_s[c];
            lost_num_s   = lost_num_s + LW'(lost_s[c]);
        end
        drop_sum_s  = {1'b0, drop_cnt_r} + 17'(lost_num_s);
        drop_next_s = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end

    assign rd_addr_s = rd_ptr_r[AW-1:0];
    assign wr_addr_s = wr_ptr_r[AW-1:0];

    // Free-running timestamp, restarted by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r <= '0;
        end else if (clear) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    // Holding registers: load new events, release on push, flush on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_r <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                hold_idx_r[c]  <= '0;
                hold_data_r[c] <= '0;
                hold_ts_r[c]   <= '0;
            end
        end else if (clear) begin
            hold_v_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (load_s[c]) begin
                    hold_v_r[c]    <= 1'b1;
                    hold_idx_r[c]  <= bus.ev_idx[c*IDX_W +: IDX_W];
                    hold_data_r[c] <= bus.ev_data[c*DATA_W +: DATA_W];
                    hold_ts_r[c]   <= ts_r;
                end else if (release_s[c]) begin
                    hold_v_r[c] <= 1'b0;
                end else begin
                    hold_v_r[c] <= hold_v_r[c];
                end
            end
        end
    end

    // FIFO pointers; an overwrite in wrap mode advances the read side too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            wr_ptr_r <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            rd_ptr_r <= (pop_s || overwrite_s) ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        end
    end

    // FIFO storage; contents are only observed while the read port is valid.
    always_ff @(posedge clk) begin
        if (push_s && !clear) begin
            mem_ch_r[wr_addr_s]   <= grant_ch_s;
            mem_idx_r[wr_addr_s]  <= hold_idx_r[grant_ch_s];
            mem_data_r[wr_addr_s] <= hold_data_r[grant_ch_s];
            mem_ts_r[wr_addr_s]   <= hold_ts_r[grant_ch_s];
        end
    end

    // Sticky overflow and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else if (clear) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            overflow_r <= overflow_r || (|lost_s) || overwrite_s;
            drop_cnt_r <= drop_next_s;
        end
    end

    assign bus.rd_valid = !empty_s;
    assign bus.rd_ch    = empty_s ? '0 : mem_ch_r[rd_addr_s];
    assign bus.rd_idx   = empty_s ? '0 : mem_idx_r[rd_addr_s];
    assign bus.rd_data  = empty_s ? '0 : mem_data_r[rd_addr_s];
    assign bus.rd_ts    = empty_s ? '0 : mem_ts_r[rd_addr_s];
    assign count        = wr_ptr_r - rd_ptr_r;
    assign overflow     = overflow_r;
    assign drop_cnt     = drop_cnt_r;
endmodule

// File: tb/tb_trace_capture_unit.sv
// Bench for trace_capture_unit: a stop-mode and a wrap-mode instance share one
// stimulus stream; a queue-based reference model predicts the drained entries.
module tb_trace_capture_unit;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 10;
    localparam int TS_W   = 8;
    localparam int DEPTH  = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 3;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic freeze = 1'b0;
    logic clear = 1'b0;
    logic rd_ready = 1'b0;
    logic [NUM_CH-1:0]        ev_valid = '0;
    logic [NUM_CH*IDX_W-1:0]  ev_idx = '0;
    logic [NUM_CH*DATA_W-1:0] ev_data = '0;

    logic [CNT_W-1:0] count0, count1;
    logic             ovf0, ovf1;
    logic [15:0]      drop0, drop1;

    int errors = 0;
    int checks = 0;

    trace_capture_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W), .TS_W(TS_W)) bus0 ();
    trace_capture_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W), .TS_W(TS_W)) bus1 ();

    assign bus0.ev_valid = ev_valid;
    assign bus0.ev_idx   = ev_idx;
    assign bus0.ev_data  = ev_data;
    assign bus0.rd_ready = rd_ready;
    assign bus1.ev_valid = ev_valid;
    assign bus1.ev_idx   = ev_idx;
    assign bus1.ev_data  = ev_data;
    assign bus1.rd_ready = rd_ready;

    trace_capture_unit #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W), .TS_W(TS_W),
                         .DEPTH(DEPTH), .WRAP_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .clear(clear), .bus(bus0),
        .count(count0), .overflow(ovf0), .drop_cnt(drop0));

    trace_capture_unit #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W), .TS_W(TS_W),
                         .DEPTH(DEPTH), .WRAP_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .clear(clear), .bus(bus1),
        .count(count1), .overflow(ovf1), .drop_cnt(drop1));

    always #5 clk = ~clk;

    // Reference model state: index 0 = stop mode, index 1 = wrap mode.
    ent_t       mq [2][DEPTH];
    int         mh [2];
    int         ms [2];
    logic       hv [2][NUM_CH];
    ent_t       he [2][NUM_CH];
    int         mdrop [2];
    logic       movf [2];
    logic [TS_W-1:0] mts;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mts = '0;
        for (int m = 0; m < 2; m++) begin
            mh[m] = 0;
            ms[m] = 0;
            mdrop[m] = 0;
            movf[m] = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                hv[m][c] = 1'b0;
                he[m][c] = '0;
            end
        end
    endtask

    // One clock edge of behaviour, computed from the current input values.
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int  g;
            int  lost;
            bit  pop;
            bit  wr;
            if (clear) begin
                mh[m] = 0;
                ms[m] = 0;
                mdrop[m] = 0;
                movf[m] = 1'b0;
                for (int c = 0; c < NUM_CH; c++) hv[m][c] = 1'b0;
            end else begin
                pop = (ms[m] > 0) && rd_ready;
                g = -1;
                for (int c = NUM_CH - 1; c >= 0; c--) if (hv[m][c]) g = c;
                wr = (g >= 0) && ((m == 1) || (ms[m] < DEPTH) || pop);
                if (pop) begin
                    mh[m] = (mh[m] + 1) % DEPTH;
                    ms[m] = ms[m] - 1;
                end else if (wr && ms[m] == DEPTH) begin
                    mh[m] = (mh[m] + 1) % DEPTH;
                    ms[m] = ms[m] - 1;
                    movf[m] = 1'b1;
                end
                if (wr) begin
                    mq[m][(mh[m] + ms[m]) % DEPTH] = he[m][g];
                    ms[m] = ms[m] + 1;
                    hv[m][g] = 1'b0;
                end
                lost = 0;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ev_valid[c] && !freeze) begin
                        if (!hv[m][c]) begin
                            hv[m][c] = 1'b1;
                            he[m][c].ch   = CH_W'(c);
                            he[m][c].idx  = ev_idx[c*IDX_W +: IDX_W];
                            he[m][c].data = ev_data[c*DATA_W +: DATA_W];
                            he[m][c].ts   = mts;
                        end else begin
                            lost++;
                        end
                    end
                end
                if (lost > 0) movf[m] = 1'b1;
                mdrop[m] = (mdrop[m] + lost > 65535) ? 65535 : mdrop[m] + lost;
            end
        end
        mts = clear ? '0 : mts + 8'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic check_port(input int m, input logic v, input logic [CH_W-1:0] ch,
                              input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data,
                              input logic [TS_W-1:0] ts, input logic [CNT_W-1:0] cnt,
                              input logic ovf, input logic [15:0] drp);
        ent_t h;
        h = '0;
        if (ms[m] > 0) h = mq[m][mh[m]];
        chk($sformatf("m%0d_rd_valid", m), 64'(v), 64'(ms[m] > 0));
        chk($sformatf("m%0d_rd_ch", m), 64'(ch), 64'(h.ch));
        chk($sformatf("m%0d_rd_idx", m), 64'(idx), 64'(h.idx));
        chk($sformatf("m%0d_rd_data", m), 64'(data), 64'(h.data));
        chk($sformatf("m%0d_rd_ts", m), 64'(ts), 64'(h.ts));
        chk($sformatf("m%0d_count", m), 64'(cnt), 64'(ms[m]));
        chk($sformatf("m%0d_overflow", m), 64'(ovf), 64'(movf[m]));
        chk($sformatf("m%0d_drop_cnt", m), 64'(drp), 64'(mdrop[m]));
    endtask

    // Monitor: mid-cycle comparison of both read ports against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check_port(0, bus0.rd_valid, bus0.rd_ch, bus0.rd_idx, bus0.rd_data, bus0.rd_ts,
                       count0, ovf0, drop0);
            check_port(1, bus1.rd_valid, bus1.rd_ch, bus1.rd_idx, bus1.rd_data, bus1.rd_ts,
                       count1, ovf1, drop1);
        end
    end

    initial begin
        logic [TS_W-1:0] t0;
        logic [CH_W-1:0] exp_ch [3];
        int guard;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_valid", 64'(bus0.rd_valid), 64'd0);
        chk("reset_count", 64'(count0), 64'd0);
        chk("reset_drop", 64'(drop1), 64'd0);
        rst_n = 1'b1;

        // Single event at timestamp 10.
        guard = 0;
        while (mts != 8'd10 && guard < 300) begin
            tick();
            guard++;
        end
        chk("ts_reach_10", 64'(mts), 64'd10);
        ev_valid = 4'b0001;
        ev_idx[IDX_W-1:0] = 10'd5;
        ev_data[DATA_W-1:0] = 32'hA5;
        tick();
        ev_valid = '0;
        chk("single_latency_1edge", 64'(bus0.rd_valid), 64'd0);
        tick();
        chk("single_valid", 64'(bus0.rd_valid), 64'd1);
        chk("single_ch", 64'(bus0.rd_ch), 64'd0);
        chk("single_idx", 64'(bus0.rd_idx), 64'd5);
        chk("single_data", 64'(bus0.rd_data), 64'hA5);
        chk("single_ts", 64'(bus0.rd_ts), 64'd10);
        chk("single_count", 64'(count0), 64'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("single_pop_count", 64'(count0), 64'd0);

        // Simultaneous events on channels 0, 1 and 3.
        t0 = mts;
        for (int c = 0; c < NUM_CH; c++) begin
            ev_idx[c*IDX_W +: IDX_W] = IDX_W'(c + 1);
            ev_data[c*DATA_W +: DATA_W] = DATA_W'(32'h100 + c);
        end
        ev_valid = 4'b1011;
        tick();
        ev_valid = '0;
        rd_ready = 1'b1;
        exp_ch[0] = 2'd0;
        exp_ch[1] = 2'd1;
        exp_ch[2] = 2'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("simul_ch%0d", k), 64'(bus0.rd_ch), 64'(exp_ch[k]));
            chk($sformatf("simul_ts%0d", k), 64'(bus0.rd_ts), 64'(t0));
        end
        tick();
        rd_ready = 1'b0;
        chk("simul_drop", 64'(drop0), 64'd0);
        chk("simul_empty", 64'(bus0.rd_valid), 64'd0);

        // Fill past capacity: stop mode drops one, wrap mode overwrites.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ev_valid = 4'b0001;
        for (int d = 1; d <= 6; d++) begin
            ev_data[DATA_W-1:0] = DATA_W'(d);
            tick();
        end
        ev_valid = '0;
        tick();
        tick();
        chk("stop_count", 64'(count0), 64'd4);
        chk("stop_drop", 64'(drop0), 64'd1);
        chk("stop_overflow", 64'(ovf0), 64'd1);
        chk("wrap_count", 64'(count1), 64'd4);
        chk("wrap_overflow", 64'(ovf1), 64'd1);
        chk("wrap_drop", 64'(drop1), 64'd0);
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stop_read%0d", k), 64'(bus0.rd_data), 64'(k + 1));
            chk($sformatf("wrap_read%0d", k), 64'(bus1.rd_data), 64'(k + 3));
            tick();
        end
        repeat (3) tick();
        rd_ready = 1'b0;

        // Clear with three entries held and a simultaneous event.
        ev_valid = 4'b0001;
        repeat (3) tick();
        ev_valid = '0;
        repeat (2) tick();
        chk("clr_pre_count", 64'(count0), 64'd3);
        clear = 1'b1;
        ev_valid = 4'b1111;
        tick();
        clear = 1'b0;
        ev_valid = '0;
        chk("clr_count", 64'(count0), 64'd0);
        chk("clr_rd_valid", 64'(bus0.rd_valid), 64'd0);
        chk("clr_drop", 64'(drop0), 64'd0);
        chk("clr_overflow", 64'(ovf1), 64'd0);
        ev_valid = 4'b0001;
        tick();
        ev_valid = '0;
        tick();
        chk("clr_ts_restart", 64'(bus0.rd_ts), 64'd0);
        chk("clr_event_discarded", 64'(count0), 64'd1);

        // Randomized traffic with varying load and drain rates.
        for (int i = 0; i < 3000; i++) begin
            int dens;
            dens = (i / 500) % 3;
            for (int c = 0; c < NUM_CH; c++) begin
                ev_valid[c] = ($urandom_range(0, 9) < (dens * 3 + 1));
                ev_idx[c*IDX_W +: IDX_W] = IDX_W'($urandom);
                ev_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            freeze = ($urandom_range(0, 19) == 0);
            clear = ($urandom_range(0, 149) == 0);
            rd_ready = ($urandom_range(0, 9) < (i % 1000 < 500 ? 3 : 8));
            tick();
        end
        ev_valid = '0;
        freeze = 1'b0;
        clear = 1'b0;

        // Asynchronous reset while the read port holds data.
        rd_ready = 1'b0;
        ev_valid = 4'b0010;
        tick();
        ev_valid = '0;
        repeat (2) tick();
        chk("arst_pre_valid", 64'(bus0.rd_valid), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_rd_valid", 64'(bus0.rd_valid), 64'd0);
        chk("arst_rd_ch", 64'(bus0.rd_ch), 64'd0);
        chk("arst_rd_idx", 64'(bus0.rd_idx), 64'd0);
        chk("arst_rd_data", 64'(bus0.rd_data), 64'd0);
        chk("arst_rd_ts", 64'(bus0.rd_ts), 64'd0);
        chk("arst_count", 64'(count1), 64'd0);
        chk("arst_overflow", 64'(ovf1), 64'd0);
        chk("arst_drop", 64'(drop0), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ev_valid = NUM_CH'($urandom);
            ev_data = {NUM_CH{DATA_W'($urandom)}};
            rd_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        ev_valid = '0;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trace_capture_unit.md
# trace_capture_unit

Synthesizable multi-channel event trace buffer for the RISC_V_Vector core. It captures architectural write events from parameterisable channels (vector RF, scalar RF, DMEM, PC) into an on-chip FIFO. Each entry is tagged with channel, index, data and a cycle timestamp. Entries drain over a valid/ready port, so in-silicon and emulation runs produce the same change logs that simulation benches write to files.

## Interface
- NUM_CH, 4: number of event channels; channel 0 has highest priority.
- DATA_W, 128: event payload width; narrower channels zero-extend.
- IDX_W, 10: register/byte index width.
- TS_W, 32: timestamp width.
- DEPTH, 64: FIFO entries; power of two, ≥2.
- WRAP_MODE, 0: 0 = stop when full; 1 = overwrite oldest.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ev_valid  in  NUM_CH  per-channel event strobe, one event per asserted cycle.
- ev_idx  in  NUM_CH*IDX_W  packed indices, channel c at [c*IDX_W +: IDX_W].
- ev_data  in  NUM_CH*DATA_W  packed payloads, same packing.
- freeze  in  1  ignore new events; not counted as drops.
- clear  in  1  synchronous flush of all state.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts head.
- rd_ch  out  clog2(NUM_CH)  head channel (min width 1).
- rd_idx  out  IDX_W  head index.
- rd_data  out  DATA_W  head payload.
- rd_ts  out  TS_W  head timestamp.
- count  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: at least one entry was overwritten (WRAP_MODE=1) or dropped.
- drop_cnt  out  16  saturating count of lost events.

## Operation
- Timestamp counter: resets to 0, then increments every cycle and wraps at 2^TS_W.
- Capture stage: one holding register per channel with fields valid, idx, data, ts.
  - If ev_valid[c] is high and freeze is low, hold[c] loads the event with the current timestamp.
  - The load succeeds if hold[c] is empty, or if hold[c] is being granted in the same cycle.
  - Otherwise the new event is lost: drop_cnt increments by the number of channels losing an event that cycle (saturating at 0xFFFF), and overflow is set.
- Arbiter: each cycle, selects the lowest-index valid hold register. The selected entry is written to the FIFO when a write is permitted:
  - WRAP_MODE=0: write only if not full, or if a pop occurs in the same cycle.
  - WRAP_MODE=1: always write. If full and no pop occurs, advance the read pointer, discard the oldest entry and set overflow. count stays at DEPTH.
- Pop: when rd_valid && rd_ready, the read pointer advances.
- Pointers: clog2(DEPTH)+1 bits each, including a wrap bit. Full when the pointers differ only in the MSB; empty when they are equal.
- Read port: rd_* shows the head combinationally from the read pointer. All rd_ch/rd_idx/rd_data/rd_ts outputs drive 0 while rd_valid=0.
- Clear: empties the FIFO and all hold registers and zeroes timestamp, overflow and drop_cnt. It takes priority over capture, write and pop in the same cycle; events presented that cycle are discarded without counting.
- Reset (asserted at any time, including mid-drain): all outputs and state go immediately to rd_valid=0, rd_* =0, count=0, overflow=0, drop_cnt=0, timestamp=0, every hold register invalid.

## Timing
- Latency: an event presented in cycle t is captured at edge t, written to the FIFO at edge t+1 if it wins arbitration, and seen as rd_valid in cycle t+1 after that edge. With an empty FIFO, minimum latency is 2 edges.
- rd_ts equals the timestamp value in the cycle ev_valid was presented.
- The arbiter grants one entry per cycle. A sustained event rate above one per cycle across all channels produces drops.
- Handshake: rd_* stays stable while rd_valid && !rd_ready. Exception: in WRAP_MODE=1 with the FIFO full, the head may change due to overwrite.
- count updates on the edge after each push or pop, and is unchanged when a push and a pop occur in the same cycle.

## Test plan
- Single event: ev_valid=0001, idx=5, data=0xA5 at timestamp 10. Required: rd_valid rises 2 edges later with ch=0, idx=5, data=0xA5, ts=10; count=1; pop returns count to 0.
- Simultaneous events: ev_valid=1011 in one cycle. Required: output order ch0, ch1, ch3, all with the same ts; drop_cnt=0.
- Stop mode full: DEPTH=4, WRAP_MODE=0, rd_ready=0, 6 events on ch0 in consecutive cycles. Required: count=4, drop_cnt=1, overflow=1; the first 4 entries read out intact.
- Wrap mode: DEPTH=4, WRAP_MODE=1, 6 events on ch0 with data 1..6, no reads. Required: count=4, reads return 3,4,5,6; overflow=1.
- Clear mid-operation: FIFO holding 3 entries, clear pulsed together with a new ev_valid. Required: next cycle count=0, rd_valid=0, drop_cnt=0, timestamp restarts at 0.
- Async reset mid-drain: rst_n pulled low between clock edges with rd_valid=1. Required: rd_valid=0 and all outputs 0 immediately, before the next edge.
